// File: rtl/logic_analyzer_pkg.sv
// rtl/logic_analyzer_pkg.sv - shared types and constants for the logic analyzer capture path
package logic_analyzer_pkg;

   localparam int DEF_ADDR_W = 18;
   localparam int DEF_DATA_W = 8;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_ABORT     = 2;
   localparam int STAT_COUNT_LSB = 13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_SEND,
      S_CKSUM,
      S_FINISH
   } state_t;

endpackage

// File: rtl/capture_readout.sv
// rtl/capture_readout.sv - streams captured BRAM samples out over a valid/ready byte stream
// Optional trailing XOR checksum beat: define CAPTURE_READOUT_CKSUM_EN.
module capture_readout
   import logic_analyzer_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int RAM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   num_samples,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_din,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_last,
   output logic [31:0]       status
);

   localparam logic [1:0]    LAT  = 2'(RAM_LATENCY);
   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] ZERO = '0;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W:0]   count;
   logic [1:0]        lat_cnt;
   logic              busy;
   logic              done;
   logic              aborted;
`ifdef CAPTURE_READOUT_CKSUM_EN
   logic [DATA_W-1:0] cksum;
`endif

   logic tx_xfer;
   assign tx_xfer = tx_valid && tx_ready;

   always_comb begin
      status = '0;
      status[STAT_BUSY]  = busy;
      status[STAT_DONE]  = done;
      status[STAT_ABORT] = aborted;
      status[STAT_COUNT_LSB +: ADDR_W+1] = count;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         addr      <= '0;
         remaining <= '0;
         count     <= '0;
         lat_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         ram_en    <= 1'b0;
         ram_addr  <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         tx_last   <= 1'b0;
`ifdef CAPTURE_READOUT_CKSUM_EN
         cksum     <= '0;
`endif
      end else if (abort && state != S_IDLE) begin
         state    <= S_IDLE;
         ram_en   <= 1'b0;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
         busy     <= 1'b0;
         aborted  <= 1'b1;
         // A sample beat completing in the abort cycle still reached the host.
         if (state == S_SEND && tx_xfer)
            count <= count + ONE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  addr      <= start_addr;
                  remaining <= num_samples;
                  count     <= '0;
                  done      <= 1'b0;
                  aborted   <= 1'b0;
                  busy      <= 1'b1;
`ifdef CAPTURE_READOUT_CKSUM_EN
                  cksum     <= '0;
`endif
                  if (num_samples == ZERO) begin
`ifdef CAPTURE_READOUT_CKSUM_EN
                     state <= S_CKSUM;
`else
                     state <= S_FINISH;
`endif
                  end else begin
                     ram_en   <= 1'b1;
                     ram_addr <= start_addr;
                     state    <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               ram_en  <= 1'b0;
               lat_cnt <= 2'd1;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (lat_cnt == LAT) begin
                  tx_data  <= ram_din;
                  tx_valid <= 1'b1;
`ifdef CAPTURE_READOUT_CKSUM_EN
                  tx_last  <= 1'b0;
`else
                  tx_last  <= (remaining == ONE);
`endif
                  state    <= S_SEND;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            S_SEND: begin
               if (tx_xfer) begin
                  tx_valid  <= 1'b0;
                  tx_last   <= 1'b0;
                  addr      <= addr + 1'b1;
                  remaining <= remaining - ONE;
                  count     <= count + ONE;
`ifdef CAPTURE_READOUT_CKSUM_EN
                  cksum     <= cksum ^ tx_data;
`endif
                  if (remaining > ONE) begin
                     // Next fetch issues immediately so a byte leaves every RAM_LATENCY+2 cycles.
                     ram_en   <= 1'b1;
                     ram_addr <= addr + 1'b1;
                     state    <= S_FETCH;
                  end else begin
`ifdef CAPTURE_READOUT_CKSUM_EN
                     state <= S_CKSUM;
`else
                     state <= S_FINISH;
`endif
                  end
               end
            end
`ifdef CAPTURE_READOUT_CKSUM_EN
            S_CKSUM: begin
               if (!tx_valid) begin
                  tx_data  <= cksum;
                  tx_valid <= 1'b1;
                  tx_last  <= 1'b1;
               end else if (tx_ready) begin
                  tx_valid <= 1'b0;
                  tx_last  <= 1'b0;
                  state    <= S_FINISH;
               end
            end
`endif
            S_FINISH: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
